fetch2: RTL and testbench

Second fetch stage of the dual-issue front end. Pairs each 64-bit instruction-memory response with the PC that requested it. Buffers the pairs in a small FIFO ahead of decode. Drives the PC write-enable back to `fetch1`, so fetch1's PC advances only when space is guaranteed for the response. On a pipeline flush, it drops all buffered and in-flight pairs.

---
 rtl/fetch2_pkg.sv | 18 +
 rtl/fetch2_pair_fifo.sv | 52 +++++
 rtl/fetch2.sv | 84 ++++++++
 tb/tb_fetch2.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch2_pkg.sv
// fetch2_pkg: shared constants and the FIFO entry layout for the fetch2 stage.
//   NOP_INST      - instruction substituted into invalid slots (addi x0,x0,0)
//   FETCH_PAIR_W  - width of one imem response (two 32-bit instructions)
//   FETCH_ENTRY_W - width of one buffered entry (PC + pair + slot mask)
package fetch2_pkg;

  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam int unsigned FETCH_PAIR_W  = 64;
  localparam int unsigned FETCH_ENTRY_W = 98;

  // One buffered instruction pair; mask[0] is slot 0, mask[1] is slot 1.
  typedef struct packed {
    logic [31:0]             pc;
    logic [FETCH_PAIR_W-1:0] data;
    logic [1:0]              mask;
  } fetch_entry_t;

endpackage

// File: rtl/fetch2_pair_fifo.sv
// fetch_pair_fifo: generic circular FIFO of WIDTH-bit entries.
//   clk, rst_n - clock, async active-low reset
//   push/pop   - enqueue push_data / dequeue head (caller guarantees legality)
//   clear      - drop all entries, has priority over push and pop
//   count      - number of valid entries (0..DEPTH)
//   head       - entry at the read pointer (undefined when count == 0)
module fetch_pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 98
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       push_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: head is only consumed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch2.sv
// fetch2: second fetch stage. Tags each imem response with the PC that requested
// it, buffers pairs ahead of decode and throttles fetch1 so a response always
// has a FIFO slot waiting for it.
//   clock_i, reset_n_i - clock, async active-low reset
//   pc_i               - address presented to imem this cycle
//   imem_data_i        - imem data for last cycle's address ([31:0] slot 0)
//   flush_i            - drop all buffered and in-flight pairs
//   decode_ready_i     - decode consumes the head pair when valid_o
//   pc_we_o            - fetch1 PC write-enable (request issued this cycle)
//   valid_o, slot_valid_o, inst0_o, inst1_o, pc_o - head pair view
module fetch2
  import fetch2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [31:0] pc_i,
  input  logic [63:0] imem_data_i,
  input  logic        flush_i,
  input  logic        decode_ready_i,
  output logic        pc_we_o,
  output logic        valid_o,
  output logic [1:0]  slot_valid_o,
  output logic [31:0] inst0_o,
  output logic [31:0] inst1_o,
  output logic [31:0] pc_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic         req_q;
  logic [31:0]  req_pc_q;
  logic [CW-1:0] count;
  logic         push;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  // Issue only when the in-flight response is guaranteed a slot; a same-cycle
  // pop is deliberately ignored so decode_ready_i has no path to pc_we_o.
  assign pc_we_o = reset_n_i & ~flush_i &
                   ((SW'(count) + SW'(req_q)) < SW'(DEPTH));

  assign push = req_q & ~flush_i;
  assign pop  = valid_o & decode_ready_i & ~flush_i;

  // A target with PC[2] set lands mid-pair, so slot 0 is not part of the stream.
  assign push_entry = '{pc: req_pc_q, data: imem_data_i, mask: {1'b1, ~req_pc_q[2]}};

  // Track the request whose response arrives next cycle.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else begin
      req_q <= pc_we_o;
      if (pc_we_o) req_pc_q <= pc_i;
    end
  end

  fetch_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk       (clock_i),
    .rst_n     (reset_n_i),
    .push      (push),
    .pop       (pop),
    .clear     (flush_i),
    .push_data (push_entry),
    .count     (count),
    .head      (head)
  );

  // Head view with NOP substitution for empty FIFO and invalid slots.
  assign valid_o      = (count != '0);
  assign slot_valid_o = valid_o ? head.mask : 2'b00;
  assign inst0_o      = (valid_o && head.mask[0]) ? head.data[31:0]  : NOP_INST;
  assign inst1_o      = (valid_o && head.mask[1]) ? head.data[63:32] : NOP_INST;
  assign pc_o         = valid_o ? head.pc : 32'h0;

endmodule

// File: tb/tb_fetch2.sv
// tb_fetch2: randomized and directed stimulus for fetch2 with a queue-based
// reference model; a negedge monitor compares the head view and pc_we_o.
module tb_fetch2;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock_i;
  logic        reset_n_i;
  logic [31:0] pc_i;
  logic [63:0] imem_data_i;
  logic        flush_i;
  logic        decode_ready_i;
  logic        pc_we_o;
  logic        valid_o;
  logic [1:0]  slot_valid_o;
  logic [31:0] inst0_o;
  logic [31:0] inst1_o;
  logic [31:0] pc_o;

  fetch2 #(.DEPTH(DEPTH)) dut (
    .clock_i        (clock_i),
    .reset_n_i      (reset_n_i),
    .pc_i           (pc_i),
    .imem_data_i    (imem_data_i),
    .flush_i        (flush_i),
    .decode_ready_i (decode_ready_i),
    .pc_we_o        (pc_we_o),
    .valid_o        (valid_o),
    .slot_valid_o   (slot_valid_o),
    .inst0_o        (inst0_o),
    .inst1_o        (inst1_o),
    .pc_o           (pc_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  typedef struct {
    logic [31:0] pc;
    logic [63:0] d;
  } pair_t;

  // Reference model: pairs decode should see, plus the one in-flight request.
  pair_t       exp_q[$];
  bit          pend;
  logic [31:0] pend_pc;
  logic [63:0] pend_data;
  bit          exp_we;
  bit          mon_en;
  logic [31:0] f1_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // Outputs sampled mid-cycle by drive(), for directed checks.
  logic        s_we, s_valid;
  logic [1:0]  s_slot;
  logic [31:0] s_inst0, s_inst1, s_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: head view against the model's front pair, and the issue gate.
  always @(negedge clock_i) begin
    if (mon_en) begin
      pair_t e;
      chk("pc_we", 64'(pc_we_o), 64'(exp_we));
      chk("valid", 64'(valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("head_pc", 64'(pc_o), 64'(e.pc));
        chk("head_slot", 64'(slot_valid_o), 64'({1'b1, ~e.pc[2]}));
        chk("head_inst0", 64'(inst0_o), 64'(e.pc[2] ? NOP : e.d[31:0]));
        chk("head_inst1", 64'(inst1_o), 64'(e.d[63:32]));
        if (decode_ready_i && !flush_i) void'(exp_q.pop_front());
      end else begin
        chk("empty_slot", 64'(slot_valid_o), 64'(0));
        chk("empty_inst0", 64'(inst0_o), 64'(NOP));
        chk("empty_inst1", 64'(inst1_o), 64'(NOP));
        chk("empty_pc", 64'(pc_o), 64'(0));
      end
    end
  end

  // One cycle; entered at posedge+1, returns at the next posedge+1.
  // mode 0: sequential fetch1 PC, 1: random PC, 2: force_pc.
  task automatic drive(input bit fl, input bit rdy, input int mode, input logic [31:0] force_pc);
    logic [63:0] next_data;
    flush_i        = fl;
    decode_ready_i = rdy;
    imem_data_i    = pend ? pend_data : {$urandom(), $urandom()};
    case (mode)
      0:       pc_i = f1_pc;
      1:       pc_i = $urandom() & 32'hFFFF_FFFC;
      default: pc_i = force_pc;
    endcase
    next_data = {$urandom(), $urandom()};
    exp_we = !fl && ((exp_q.size() + int'(pend)) < DEPTH);
    @(negedge clock_i);
    #2;
    s_we = pc_we_o; s_valid = valid_o; s_slot = slot_valid_o;
    s_inst0 = inst0_o; s_inst1 = inst1_o; s_pc = pc_o;
    if (fl) begin
      exp_q.delete();
      pend = 0;
    end else begin
      if (pend) begin
        if (exp_q.size() >= DEPTH) begin
          n_bad++;
          $display("FAIL model_overflow: size %0d at push (t=%0t)", exp_q.size(), $time);
        end
        exp_q.push_back('{pc: pend_pc, d: pend_data});
      end
      pend      = exp_we;
      pend_pc   = pc_i;
      pend_data = next_data;
    end
    if (mode == 0 && exp_we) f1_pc = f1_pc + 32'd8;
    @(posedge clock_i);
    #1;
  endtask

  // Hold reset two edges, check reset view, release at posedge+1 (cycle 1 follows).
  task automatic do_reset();
    mon_en = 0;
    reset_n_i = 1'b0;
    flush_i = 1'b0;
    decode_ready_i = 1'b0;
    exp_q.delete();
    pend = 0;
    f1_pc = 32'd8;
    repeat (2) @(posedge clock_i);
    #1;
    chk("rst_pc_we", 64'(pc_we_o), 64'(0));
    chk("rst_valid", 64'(valid_o), 64'(0));
    reset_n_i = 1'b1;
    mon_en = 1;
  endtask

  // Sequential fetch with decode always ready: first pair at cycle 3, no gaps.
  task automatic seq_run();
    for (int c = 1; c <= 12; c++) begin
      drive(0, 1, 0, 32'h0);
      if (c == 1) chk("c1_pc_we", 64'(s_we), 64'(1));
      if (c < 3) chk("early_valid", 64'(s_valid), 64'(0));
      else begin
        chk("stream_valid", 64'(s_valid), 64'(1));
        chk("stream_pc", 64'(s_pc), 64'(32'(8 * (c - 2))));
      end
    end
  endtask

  initial begin
    int we_cnt;
    int guard;
    logic [63:0] rec;
    reset_n_i = 1'b0;
    pc_i = '0;
    imem_data_i = '0;
    flush_i = 1'b0;
    decode_ready_i = 1'b0;
    mon_en = 0;
    pend = 0;
    exp_we = 0;
    f1_pc = 32'd8;

    // Reset release and steady-state throughput.
    do_reset();
    seq_run();

    // Backpressure from reset: exactly DEPTH issues, then drain in order.
    do_reset();
    we_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 32'h0);
      if (s_we) we_cnt++;
    end
    chk("bp_issue_count", 64'(we_cnt), 64'(DEPTH));
    chk("bp_pc_we_held", 64'(s_we), 64'(0));
    for (int c = 0; c < 8; c++) drive(0, 1, 0, 32'h0);

    // Flush with count=3 and a response in flight.
    do_reset();
    guard = 0;
    while (!(exp_q.size() == 3 && pend) && guard < 10) begin
      drive(0, 0, 0, 32'h0);
      guard++;
    end
    if (guard >= 10) begin
      n_bad++;
      $display("FAIL flush_setup: count=3/req=1 not reached in %0d cycles", guard);
    end
    drive(1, 0, 0, 32'h0);
    chk("flush_cycle_we", 64'(s_we), 64'(0));
    drive(0, 0, 0, 32'h0);
    chk("post_flush_valid", 64'(s_valid), 64'(0));
    chk("post_flush_we", 64'(s_we), 64'(1));
    drive(0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0);
    chk("post_flush_refill", 64'(s_valid), 64'(1));

    // Misaligned target: slot 0 invalid.
    do_reset();
    drive(0, 0, 2, 32'h0000_0104);
    rec = pend_data;
    drive(0, 0, 1, 32'h0);
    drive(0, 0, 1, 32'h0);
    chk("mis_slot", 64'(s_slot), 64'(2'b10));
    chk("mis_inst0", 64'(s_inst0), 64'(NOP));
    chk("mis_inst1", 64'(s_inst1), 64'(rec[63:32]));
    chk("mis_pc", 64'(s_pc), 64'(32'h0000_0104));

    // Random traffic: push/pop at full and near-empty, occasional flush.
    do_reset();
    for (int c = 0; c < 400; c++)
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1, 32'h0);

    // Asynchronous reset mid-stream with the FIFO half full.
    do_reset();
    guard = 0;
    while (exp_q.size() != DEPTH / 2 && guard < 10) begin
      drive(0, 0, 0, 32'h0);
      guard++;
    end
    chk("half_full_valid", 64'(valid_o), 64'(1));
    #2;
    mon_en = 0;
    reset_n_i = 1'b0;
    #1;
    chk("async_valid", 64'(valid_o), 64'(0));
    chk("async_pc_we", 64'(pc_we_o), 64'(0));
    chk("async_slot", 64'(slot_valid_o), 64'(0));
    chk("async_inst0", 64'(inst0_o), 64'(NOP));
    chk("async_inst1", 64'(inst1_o), 64'(NOP));
    chk("async_pc", 64'(pc_o), 64'(0));
    do_reset();
    seq_run();

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
